secuenciador_grabacion: RTL and testbench
=========================================

Name: secuenciador_grabacion

Overview:
- Record/playback controller for the piano note memory.
- In record mode it samples the live note code at a fixed slot rate and writes it to a synchronous-read note RAM.
- In play mode it reads the stored codes back at the same rate and drives the 8-bit note code consumed by the octave/note display decoder.
- Sits between the keyboard/note encoder, the note RAM, and the display/sound path.

Parameters:
- ADDR_W, 6, RAM address width; DEPTH = 2**ADDR_W slots.
- TICK_DIV, 25000000, clock cycles per note slot; must be >= 2.
- LOOP, 0, 1 = playback wraps to slot 0 instead of stopping.
- NOTA_MAX, 65, highest legal note code; codes > NOTA_MAX are stored as 0 (silence).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_grabar  in  1  one-cycle pulse, start recording.
- btn_reproducir  in  1  one-cycle pulse, start playback.
- btn_parar  in  1  one-cycle pulse, stop current mode.
- nota_in  in  8  live note code (0 = silence, 1..65 = octave*13 + note).
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data, valid 1 cycle after address.
- nota_salida  out  8  note code to display decoder.
- estado  out  2  0 = IDLE, 1 = GRABANDO, 2 = REPRODUCIENDO.
- largo  out  ADDR_W+1  number of recorded slots (0..DEPTH).

Behaviour:
- Reset (async, rst_n = 0): estado = IDLE; largo = 0; nota_salida = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; wr_ptr = rd_ptr = 0; div_cnt = 0. RAM contents are not cleared.
- Reset mid-operation discards the recording (largo = 0).
- Slot timer: div_cnt counts 0..TICK_DIV-1 and wraps. It is forced to 0 on the edge that enters GRABANDO or REPRODUCIENDO. tick = (div_cnt == 0) while in an active state.
- Button priority when several are high in the same cycle: btn_parar > btn_grabar > btn_reproducir.
- IDLE:
  - nota_salida = 0, mem_we = 0.
  - btn_grabar -> GRABANDO with wr_ptr = 0.
  - btn_reproducir with largo != 0 -> REPRODUCIENDO with rd_ptr = 0.
  - btn_reproducir with largo == 0 -> stay in IDLE.
  - btn_parar -> no effect.
- GRABANDO:
  - On each tick, for one cycle: mem_we = 1, mem_addr = wr_ptr, mem_wdata = sanitized nota_in. wr_ptr increments the next cycle.
  - The first write happens in the first cycle of GRABANDO.
  - nota_salida follows nota_in, registered with 1-cycle latency, so the player hears what is being recorded.
  - When the write to slot DEPTH-1 completes: largo = DEPTH, go to IDLE.
  - btn_parar: largo = wr_ptr (writes completed so far), go to IDLE. A write coinciding with btn_parar is suppressed.
  - btn_grabar restarts recording: wr_ptr = 0, div_cnt = 0.
  - btn_reproducir is ignored.
- REPRODUCIENDO:
  - On each tick with rd_ptr < largo: mem_addr = rd_ptr and rd_ptr increments.
  - On the following cycle: nota_salida <= mem_rdata (2-cycle latency from tick to output). nota_salida holds until the next update.
  - Tick with rd_ptr == largo:
    - LOOP = 0: nota_salida = 0, go to IDLE.
    - LOOP = 1: rd_ptr wraps to 0 and the read of slot 0 is issued on that same tick.
  - btn_parar: nota_salida = 0, go to IDLE.
  - btn_reproducir restarts from slot 0.
  - btn_grabar goes to GRABANDO; the old length is kept until the new recording ends.
- mem_we is never asserted outside GRABANDO.
- largo changes only on record end or reset.

Test Plan (ADDR_W = 3, TICK_DIV = 4, LOOP = 0 unless noted):
- Reset release, no buttons -> estado = 0, largo = 0, nota_salida = 0, mem_we never high for 50 cycles.
- btn_grabar, then nota_in = 14, 27, 70, 5 held 4 cycles each, then btn_parar -> RAM writes {14, 27, 0, 5} at addresses 0..3, one every 4 cycles starting the cycle after the pulse; largo = 4; estado = 0.
- Continuing, btn_reproducir -> nota_salida = 14, 27, 0, 5, each appearing 2 cycles after its tick and held 4 cycles; then nota_salida = 0 and estado = 0 at tick 5.
- btn_grabar and hold nota_in = 40 with no stop -> exactly 8 writes (addresses 0..7), then largo = 8 and estado = 0 automatically.
- LOOP = 1, largo = 2 with {1, 65} -> nota_salida cycles 1, 65, 1, 65, … until btn_parar; on btn_parar, nota_salida = 0 the next cycle.
- Same-cycle btn_parar + btn_grabar during REPRODUCIENDO -> IDLE, no write. Same-cycle btn_grabar + btn_reproducir in IDLE -> GRABANDO. rst_n pulled low mid-recording -> all outputs 0 asynchronously and largo = 0.

Source files
------------

// File: rtl/secuenciador_grabacion_if.sv
// rtl/secuenciador_grabacion_if.sv - button, note, RAM and status bundle of the record/playback sequencer
interface secuenciador_grabacion_if #(
    parameter int ADDR_W = 6
);
    logic              btn_grabar;
    logic              btn_reproducir;
    logic              btn_parar;
    logic [7:0]        nota_in;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic [7:0]        nota_salida;
    logic [1:0]        estado;
    logic [ADDR_W:0]   largo;

    modport slave (
        input  btn_grabar, btn_reproducir, btn_parar, nota_in, mem_rdata,
        output mem_we, mem_addr, mem_wdata, nota_salida, estado, largo
    );

    modport master (
        output btn_grabar, btn_reproducir, btn_parar, nota_in, mem_rdata,
        input  mem_we, mem_addr, mem_wdata, nota_salida, estado, largo
    );
endinterface

// File: rtl/secuenciador_grabacion.sv
// rtl/secuenciador_grabacion.sv - piano note record/playback sequencer over a synchronous-read note RAM
module secuenciador_grabacion #(
    parameter int ADDR_W   = 6,
    parameter int TICK_DIV = 25000000,
    parameter bit LOOP     = 1'b0,
    parameter int NOTA_MAX = 65
) (
    input logic                     clk,
    input logic                     rst_n,
    secuenciador_grabacion_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_UNO = DIV_W'(1);
    localparam logic [ADDR_W-1:0] WR_UNO  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   RD_UNO  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   LLENO   = (ADDR_W + 1)'(DEPTH);
    localparam logic [7:0]        NMAX    = 8'(NOTA_MAX);

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        GRABANDO      = 2'd1,
        REPRODUCIENDO = 2'd2
    } estado_t;

    estado_t           state, state_next;
    logic [DIV_W-1:0]  div_cnt, div_next, div_inc;
    logic [ADDR_W-1:0] wr_ptr, wr_next;
    logic [ADDR_W:0]   rd_ptr, rd_next;
    logic [ADDR_W:0]   largo_q, largo_next;
    logic [7:0]        nota_q, nota_next;
    logic              rd_pend, rd_pend_next;

    logic       tick;
    logic       wr_en;
    logic       rd_go;
    logic       rd_wrap;
    logic [7:0] nota_limpia;

    assign tick        = (state != IDLE) && (div_cnt == '0);
    assign div_inc     = (div_cnt == DIV_MAX) ? '0 : div_cnt + DIV_UNO;
    assign nota_limpia = (bus.nota_in > NMAX) ? 8'd0 : bus.nota_in;

    // A restart or stop in the tick cycle cancels the write of that slot.
    assign wr_en   = (state == GRABANDO) && tick && !bus.btn_parar && !bus.btn_grabar;
    assign rd_go   = (state == REPRODUCIENDO) && tick &&
                     !bus.btn_parar && !bus.btn_grabar && !bus.btn_reproducir;
    assign rd_wrap = LOOP && rd_go && (rd_ptr >= largo_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            largo_q <= '0;
            nota_q  <= '0;
            rd_pend <= 1'b0;
        end else begin
            state   <= state_next;
            div_cnt <= div_next;
            wr_ptr  <= wr_next;
            rd_ptr  <= rd_next;
            largo_q <= largo_next;
            nota_q  <= nota_next;
            rd_pend <= rd_pend_next;
        end
    end

    always_comb begin
        state_next   = state;
        div_next     = '0;
        wr_next      = wr_ptr;
        rd_next      = rd_ptr;
        largo_next   = largo_q;
        nota_next    = nota_q;
        rd_pend_next = 1'b0;
        case (state)
            IDLE: begin
                nota_next = '0;
                if (!bus.btn_parar) begin
                    if (bus.btn_grabar) begin
                        state_next = GRABANDO;
                        wr_next    = '0;
                        nota_next  = bus.nota_in;
                    end else if (bus.btn_reproducir && (largo_q != '0)) begin
                        state_next = REPRODUCIENDO;
                        rd_next    = '0;
                    end
                end
            end
            GRABANDO: begin
                div_next  = div_inc;
                nota_next = bus.nota_in;
                if (bus.btn_parar) begin
                    state_next = IDLE;
                    largo_next = {1'b0, wr_ptr};
                    nota_next  = '0;
                    div_next   = '0;
                end else if (bus.btn_grabar) begin
                    wr_next  = '0;
                    div_next = '0;
                end else if (wr_en) begin
                    if (wr_ptr == '1) begin
                        state_next = IDLE;
                        largo_next = LLENO;
                        nota_next  = '0;
                        div_next   = '0;
                        wr_next    = '0;
                    end else begin
                        wr_next = wr_ptr + WR_UNO;
                    end
                end
            end
            REPRODUCIENDO: begin
                div_next = div_inc;
                // Data for the address issued last cycle is on mem_rdata now.
                if (rd_pend) nota_next = bus.mem_rdata;
                if (bus.btn_parar) begin
                    state_next = IDLE;
                    nota_next  = '0;
                    div_next   = '0;
                end else if (bus.btn_grabar) begin
                    state_next = GRABANDO;
                    wr_next    = '0;
                    nota_next  = bus.nota_in;
                    div_next   = '0;
                end else if (bus.btn_reproducir) begin
                    rd_next  = '0;
                    div_next = '0;
                end else if (rd_go) begin
                    if (rd_ptr < largo_q) begin
                        rd_next      = rd_ptr + RD_UNO;
                        rd_pend_next = 1'b1;
                    end else if (rd_wrap) begin
                        rd_next      = RD_UNO;
                        rd_pend_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                        nota_next  = '0;
                        div_next   = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                nota_next  = '0;
            end
        endcase
    end

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            GRABANDO: begin
                bus.mem_we    = wr_en;
                bus.mem_addr  = wr_ptr;
                bus.mem_wdata = wr_en ? nota_limpia : 8'd0;
            end
            REPRODUCIENDO: begin
                bus.mem_addr = rd_wrap ? '0 : rd_ptr[ADDR_W-1:0];
            end
            default: begin
                bus.mem_we = 1'b0;
            end
        endcase
    end

    assign bus.estado      = state;
    assign bus.nota_salida = nota_q;
    assign bus.largo       = largo_q;
endmodule

// File: tb/tb_secuenciador_grabacion.sv
// tb/tb_secuenciador_grabacion.sv - scoreboard bench for the record/playback sequencer
module tb_secuenciador_grabacion;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    secuenciador_grabacion_if #(.ADDR_W(AW)) bus ();
    secuenciador_grabacion_if #(.ADDR_W(AW)) bus_l ();

    secuenciador_grabacion #(.ADDR_W(AW), .TICK_DIV(4), .LOOP(1'b0), .NOTA_MAX(65)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    secuenciador_grabacion #(.ADDR_W(AW), .TICK_DIV(4), .LOOP(1'b1), .NOTA_MAX(65)) dut_l (
        .clk(clk), .rst_n(rst_n), .bus(bus_l)
    );

    assign bus_l.btn_grabar     = bus.btn_grabar;
    assign bus_l.btn_reproducir = bus.btn_reproducir;
    assign bus_l.btn_parar      = bus.btn_parar;
    assign bus_l.nota_in        = bus.nota_in;

    logic [7:0] ram   [0:7];
    logic [7:0] ram_l [0:7];

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
        if (bus_l.mem_we) ram_l[bus_l.mem_addr] <= bus_l.mem_wdata;
        bus_l.mem_rdata <= ram_l[bus_l.mem_addr];
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    typedef struct {
        int val;
        int gap;
    } nt_t;

    wr_t        exp_wr[$];
    nt_t        exp_n[$];
    nt_t        exp_l[$];
    bit         mon_n = 1'b0;
    bit         mon_l = 1'b0;
    logic [7:0] prev_n, prev_l;
    int         last_n, last_l;

    task automatic chk(input string name, input int act, input int expv);
        vecs++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic arm_n();
        prev_n = bus.nota_salida;
        last_n = cyc;
        mon_n  = 1'b1;
    endtask

    task automatic arm_l();
        prev_l = bus_l.nota_salida;
        last_l = cyc;
        mon_l  = 1'b1;
    endtask

    task automatic push_wr(input int a, input int d);
        wr_t w;
        w.addr = AW'(a);
        w.data = 8'(d);
        exp_wr.push_back(w);
    endtask

    task automatic push_n(input int v, input int g);
        nt_t e;
        e.val = v;
        e.gap = g;
        exp_n.push_back(e);
    endtask

    task automatic push_l(input int v, input int g);
        nt_t e;
        e.val = v;
        e.gap = g;
        exp_l.push_back(e);
    endtask

    // RAM write monitor: every mem_we pulse must match the next queued write.
    always @(negedge clk) begin
        if (rst_n && bus.mem_we) begin
            if (exp_wr.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL wr_extra: got addr %0d data %0d expected no write", bus.mem_addr, bus.mem_wdata);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                chk("wr_addr", int'(bus.mem_addr), int'(w.addr));
                chk("wr_data", int'(bus.mem_wdata), int'(w.data));
            end
        end
    end

    // Note output monitors: each change is compared for value and cycles since the last change.
    always @(negedge clk) begin
        if (mon_n && (bus.nota_salida != prev_n)) begin
            if (exp_n.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL nota_extra: got %0d expected no change", bus.nota_salida);
            end else begin
                nt_t e;
                e = exp_n.pop_front();
                chk("nota_val", int'(bus.nota_salida), e.val);
                chk("nota_gap", cyc - last_n, e.gap);
            end
            last_n = cyc;
            prev_n = bus.nota_salida;
        end
    end

    always @(negedge clk) begin
        if (mon_l && (bus_l.nota_salida != prev_l)) begin
            if (exp_l.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL loop_extra: got %0d expected no change", bus_l.nota_salida);
            end else begin
                nt_t e;
                e = exp_l.pop_front();
                chk("loop_val", int'(bus_l.nota_salida), e.val);
                chk("loop_gap", cyc - last_l, e.gap);
            end
            last_l = cyc;
            prev_l = bus_l.nota_salida;
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            ram[i]   = 8'd0;
            ram_l[i] = 8'd0;
        end
        bus.btn_grabar     = 1'b0;
        bus.btn_reproducir = 1'b0;
        bus.btn_parar      = 1'b0;
        bus.nota_in        = 8'd0;

        step(3);
        rst_n = 1'b1;
        chk("rst_estado", int'(bus.estado), 0);
        chk("rst_largo", int'(bus.largo), 0);
        chk("rst_nota", int'(bus.nota_salida), 0);
        chk("rst_addr", int'(bus.mem_addr), 0);
        step(50);
        chk("idle_estado", int'(bus.estado), 0);
        chk("idle_largo", int'(bus.largo), 0);

        // Four-slot recording with one illegal code and a manual stop.
        push_wr(0, 14); push_wr(1, 27); push_wr(2, 0); push_wr(3, 5);
        bus.btn_grabar = 1'b1; bus.nota_in = 8'd14;
        step; bus.btn_grabar = 1'b0;
        chk("rec_estado", int'(bus.estado), 1);
        step(3); bus.nota_in = 8'd27;
        step(4); bus.nota_in = 8'd70;
        step(4); bus.nota_in = 8'd5;
        step(4); bus.btn_parar = 1'b1;
        step; bus.btn_parar = 1'b0;
        chk("stop_estado", int'(bus.estado), 0);
        chk("stop_largo", int'(bus.largo), 4);

        // Playback of the four slots, then automatic return to idle.
        step; arm_n();
        push_n(14, 3); push_n(27, 4); push_n(0, 4); push_n(5, 4); push_n(0, 3);
        bus.btn_reproducir = 1'b1;
        step; bus.btn_reproducir = 1'b0;
        chk("play_estado", int'(bus.estado), 2);
        step(20);
        chk("play_end_estado", int'(bus.estado), 0);
        chk("play_end_nota", int'(bus.nota_salida), 0);
        chk("play_pending", exp_n.size(), 0);
        mon_n = 1'b0;

        // Full-memory recording ends by itself after eight writes.
        for (int i = 0; i < 8; i++) push_wr(i, 40);
        arm_n(); push_n(40, 1); push_n(0, 29);
        bus.btn_grabar = 1'b1; bus.nota_in = 8'd40;
        step; bus.btn_grabar = 1'b0;
        step(14);
        chk("full_mid_estado", int'(bus.estado), 1);
        chk("full_mid_largo", int'(bus.largo), 4);
        step(20);
        chk("full_estado", int'(bus.estado), 0);
        chk("full_largo", int'(bus.largo), 8);
        chk("full_pending", exp_n.size(), 0);
        mon_n = 1'b0;

        // Two-slot recording, played on both the stopping and the looping instance.
        push_wr(0, 1); push_wr(1, 65);
        bus.btn_grabar = 1'b1; bus.nota_in = 8'd1;
        step; bus.btn_grabar = 1'b0;
        step(3); bus.nota_in = 8'd65;
        step(2); bus.btn_parar = 1'b1;
        step; bus.btn_parar = 1'b0;
        chk("two_largo", int'(bus.largo), 2);
        chk("two_largo_l", int'(bus_l.largo), 2);
        step; arm_n(); arm_l();
        push_n(1, 3); push_n(65, 4); push_n(0, 3);
        push_l(1, 3); push_l(65, 4); push_l(1, 4); push_l(65, 4); push_l(1, 4); push_l(0, 2);
        bus.btn_reproducir = 1'b1;
        step; bus.btn_reproducir = 1'b0;
        step(19); bus.btn_parar = 1'b1;
        step; bus.btn_parar = 1'b0;
        step(2);
        chk("loop_estado", int'(bus_l.estado), 0);
        chk("loop_pending", exp_l.size(), 0);
        chk("once_pending", exp_n.size(), 0);
        mon_n = 1'b0;
        mon_l = 1'b0;

        // Stop beats record while playing; record beats play while idle.
        bus.btn_reproducir = 1'b1;
        step; bus.btn_reproducir = 1'b0;
        step(3);
        bus.btn_parar = 1'b1; bus.btn_grabar = 1'b1;
        step; bus.btn_parar = 1'b0; bus.btn_grabar = 1'b0;
        chk("prio_stop_estado", int'(bus.estado), 0);
        chk("prio_stop_nota", int'(bus.nota_salida), 0);
        step(6);
        chk("prio_idle_estado", int'(bus.estado), 0);
        push_wr(0, 22); push_wr(1, 33);
        bus.nota_in = 8'd22; bus.btn_grabar = 1'b1; bus.btn_reproducir = 1'b1;
        step; bus.btn_grabar = 1'b0; bus.btn_reproducir = 1'b0;
        chk("prio_rec_estado", int'(bus.estado), 1);

        // Asynchronous reset in the middle of a recording.
        step(3); bus.nota_in = 8'd33;
        step(2);
        chk("pre_rst_nota", int'(bus.nota_salida), 33);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_estado", int'(bus.estado), 0);
        chk("arst_largo", int'(bus.largo), 0);
        chk("arst_nota", int'(bus.nota_salida), 0);
        chk("arst_we", int'(bus.mem_we), 0);
        chk("arst_addr", int'(bus.mem_addr), 0);
        chk("arst_wdata", int'(bus.mem_wdata), 0);
        step; rst_n = 1'b1;
        step;
        bus.btn_reproducir = 1'b1;
        step; bus.btn_reproducir = 1'b0;
        chk("empty_play_estado", int'(bus.estado), 0);
        chk("empty_play_largo", int'(bus.largo), 0);
        step(8);
        chk("wr_pending", exp_wr.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
